wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter between functional-unit result buses and the physical register file's write ports. Each of NUM_SOURCES producers pushes (physical index, data) results through a valid/ready handshake into a private FIFO. Every cycle the block grants up to NUM_WRITE_PORTS non-empty FIFOs in round-robin order and drives the register file's `RegFileWritePort` array from a register stage. It is the producer side of the register file write interface.

## Interface
- WORD_SIZE, reg_pkg::WORD_SIZE, data width.
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS, physical register count; index width IW = $clog2(NUM_PHYS_REGS).
- NUM_SOURCES, 4, number of producer result buses.
- NUM_WRITE_PORTS, 2, register file write ports driven; must be ≤ NUM_SOURCES.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- src_valid  in  NUM_SOURCES  producer i presents a result.
- src_ready  out  NUM_SOURCES  FIFO i can accept.
- src_index  in  IW × NUM_SOURCES (unpacked array)  destination physical register per source.
- src_data  in  WORD_SIZE × NUM_SOURCES (unpacked array)  result data per source.
- write_ports  out  RegFileWritePort [NUM_WRITE_PORTS-1:0]  fields en, index_in, data_in; registered.

## Operation
- Accept: a transfer on source i occurs at an edge where src_valid[i] && src_ready[i]. The {index, data} pair is written at FIFO i's tail.
- src_ready[i] = (count_i < FIFO_DEPTH) && !rst. It depends only on state, never on src_valid. A full FIFO deasserts ready even when it pops in the same cycle; there is no pass-through.
- src_index and src_data are ignored when src_valid is low or src_ready is low.
- Arbitration (combinational, from FIFO state):
  - Scan sources starting at rr_ptr, wrapping modulo NUM_SOURCES.
  - The first non-empty FIFO goes to port 0, the second to port 1, and so on, up to NUM_WRITE_PORTS grants.
  - Each source gets at most one grant per cycle.
- On each edge, granted FIFOs pop their head into the assigned write_ports[p] register with en=1. Ungranted ports load en=0, index_in=0, data_in=0.
- rr_ptr update:
  - With one or more grants, rr_ptr becomes (last granted source + 1) mod NUM_SOURCES.
  - With no grants, rr_ptr is unchanged.
- Per-source order is preserved (FIFO). Cross-source order follows the arbitration.
- Duplicate indices in the same cycle are not detected. Producers guarantee distinct destination registers; the arbiter makes no check.
- Enqueue and pop on the same FIFO in the same edge are both performed and the count is unchanged.
- Counts use $clog2(FIFO_DEPTH)+1 bits. Head and tail pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset, checked at the edge while rst=1:
  - all FIFOs emptied (count=0, pointers=0);
  - rr_ptr=0;
  - every write_ports[p] = {en=0, index_in=0, data_in=0};
  - src_ready=0 while rst is high, all 1 in the first cycle after rst deasserts.
- Reset mid-operation discards all queued and in-flight results. write_ports.en is 0 in the cycle after the reset edge, even if it was 1 before.
- Latency, with no contention:
  - handshake at edge E0;
  - the entry is at the FIFO head in the cycle after E0 and is granted;
  - it pops at E1, so write_ports.en=1 in the cycle after E1;
  - the register file commits at E2.
  - Minimum latency is 2 edges from handshake to write_ports.en.
- Throughput: NUM_WRITE_PORTS results per cycle total, one per source per cycle.
- A source that is continuously full sees src_ready toggle. Sustained rate per source is one per cycle only when it is granted every cycle.
- Starvation bound: any non-empty FIFO is granted within ceil(NUM_SOURCES / NUM_WRITE_PORTS) cycles.

## Test plan
- Single write, defaults: source 2 handshakes index=5, data=0xDEAD at edge E0. Required: write_ports[0] = {en=1, index_in=5, data_in=0xDEAD} exactly in the cycle after E1, port 1 en=0, and rr_ptr=3 afterwards.
- Four sources (indices 10–13) handshake at the same edge from rr_ptr=0. Required:
  - first cycle: ports {0:10, 1:11};
  - next cycle: ports {0:12, 1:13};
  - then en=0 on both ports;
  - rr_ptr=0 at the end.
- Backpressure: hold the ports busy with sources 0 and 1 while source 3 pushes every cycle, FIFO_DEPTH=2. Required: src_ready[3] drops after 2 accepted-but-unpopped entries, no entry is lost or duplicated, and source 3's outputs appear in push order.
- Fairness: all four sources continuously valid. Required: over 8 cycles each source is granted exactly 4 times, and grants rotate {0,1}, {2,3}, {0,1}, and so on.
- Reset mid-flight: fill all FIFOs, then assert rst for one cycle. Required:
  - write_ports en=0 in the following cycle;
  - src_ready=0 during rst and all 1 after;
  - no pre-reset data ever appears on write_ports.
- Same-edge push and pop on a FIFO holding 1 entry: count stays 1 and ordering is correct.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding the register file write ports
// through a round-robin grant stage and a registered output stage.

package reg_pkg;
    localparam int unsigned WORD_SIZE     = 32;
    localparam int unsigned NUM_PHYS_REGS = 64;
    localparam int unsigned IW            = $clog2(NUM_PHYS_REGS);

    typedef struct packed {
        logic                 en;
        logic [IW-1:0]        index_in;
        logic [WORD_SIZE-1:0] data_in;
    } RegFileWritePort;
endpackage

module wb_arbiter #(
    parameter int unsigned WORD_SIZE       = reg_pkg::WORD_SIZE,
    parameter int unsigned NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
    parameter int unsigned NUM_SOURCES     = 4,
    parameter int unsigned NUM_WRITE_PORTS = 2,
    parameter int unsigned FIFO_DEPTH      = 2,
    localparam int unsigned IW             = $clog2(NUM_PHYS_REGS)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_SOURCES-1:0]                        src_valid,
    output logic [NUM_SOURCES-1:0]                        src_ready,
    input  logic [IW-1:0]                                 src_index [NUM_SOURCES],
    input  logic [WORD_SIZE-1:0]                          src_data  [NUM_SOURCES],
    output reg_pkg::RegFileWritePort [NUM_WRITE_PORTS-1:0] write_ports
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [IW-1:0]        idx_mem  [NUM_SOURCES][FIFO_DEPTH];
    logic [WORD_SIZE-1:0] data_mem [NUM_SOURCES][FIFO_DEPTH];
    logic [PW-1:0]        head     [NUM_SOURCES];
    logic [PW-1:0]        tail     [NUM_SOURCES];
    logic [CW-1:0]        count    [NUM_SOURCES];
    logic [SW-1:0]        rr_ptr;

    logic [SW-1:0]        rr_next;
    logic [NUM_SOURCES-1:0] push;
    logic [NUM_SOURCES-1:0] grant;
    logic [NUM_WRITE_PORTS-1:0] port_valid;
    logic [SW-1:0]        port_src   [NUM_WRITE_PORTS];
    logic [IW-1:0]        head_index [NUM_SOURCES];
    logic [WORD_SIZE-1:0] head_data  [NUM_SOURCES];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready is a pure function of occupancy, so a full FIFO never passes through.
    always_comb begin
        for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
            src_ready[s]  = (count[s] < CW'(FIFO_DEPTH)) && !rst;
            push[s]       = src_valid[s] && src_ready[s];
            head_index[s] = idx_mem[s][head[s]];
            head_data[s]  = data_mem[s][head[s]];
        end
    end

    // Round-robin scan from rr_ptr; the k-th non-empty source lands on port k.
    always_comb begin
        int unsigned n;
        int unsigned s;
        grant      = '0;
        port_valid = '0;
        rr_next    = rr_ptr;
        n          = 0;
        s          = 0;
        for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
            port_src[p] = '0;
        end
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            s = 32'(rr_ptr) + k;
            if (s >= NUM_SOURCES) begin
                s = s - NUM_SOURCES;
            end
            if ((count[s] != '0) && (n < NUM_WRITE_PORTS)) begin
                grant[s]      = 1'b1;
                port_valid[n] = 1'b1;
                port_src[n]   = SW'(s);
                rr_next       = (s == NUM_SOURCES - 1) ? '0 : SW'(s + 1);
                n             = n + 1;
            end
        end
    end

    // FIFO bookkeeping and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
                count[s] <= '0;
                head[s]  <= '0;
                tail[s]  <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
                if (push[s]) begin
                    tail[s] <= ptr_inc(tail[s]);
                end
                if (grant[s]) begin
                    head[s] <= ptr_inc(head[s]);
                end
                if (push[s] && !grant[s]) begin
                    count[s] <= count[s] + CW'(1);
                end else if (!push[s] && grant[s]) begin
                    count[s] <= count[s] - CW'(1);
                end
            end
        end
    end

    // Storage needs no reset: only entries counted as valid are ever read out.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_SOURCES; s++) begin
            if (push[s]) begin
                idx_mem[s][tail[s]]  <= src_index[s];
                data_mem[s][tail[s]] <= src_data[s];
            end
        end
    end

    // Registered write-port stage; idle ports are driven to all zeros.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (rst || !port_valid[p]) begin
                write_ports[p] <= '0;
            end else begin
                write_ports[p].en       <= 1'b1;
                write_ports[p].index_in <= head_index[port_src[p]];
                write_ports[p].data_in  <= head_data[port_src[p]];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_wb_arbiter;

    localparam int unsigned NS    = 4;
    localparam int unsigned NWP   = 2;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned WS    = reg_pkg::WORD_SIZE;
    localparam int unsigned IW    = reg_pkg::IW;
    localparam int unsigned PWID  = 1 + IW + WS;

    typedef logic [IW+WS-1:0] entry_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NS-1:0]        src_valid;
    logic [NS-1:0]        src_ready;
    logic [IW-1:0]        src_index [NS];
    logic [WS-1:0]        src_data  [NS];
    reg_pkg::RegFileWritePort [NWP-1:0] write_ports;

    int errors = 0;
    int checks = 0;

    wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_index   (src_index),
        .src_data    (src_data),
        .write_ports (write_ports)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pv(input logic en, input int idx, input logic [31:0] d);
        return 64'({en, IW'(idx), WS'(d)});
    endfunction

    // Reference model: one queue per source, rotating scan over non-empty queues.
    entry_t          mq [NS][$];
    int unsigned     mrr;
    logic [PWID-1:0] exp_ports [NWP];
    bit              model_on = 1'b0;

    always @(posedge clk) begin : model
        bit [NS-1:0] rdy;
        int unsigned g [$];
        int unsigned s;
        entry_t      e;
        if (rst) begin
            for (int unsigned i = 0; i < NS; i++) mq[i].delete();
            mrr = 0;
            for (int unsigned p = 0; p < NWP; p++) exp_ports[p] = '0;
            model_on = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NS; i++) rdy[i] = (mq[i].size() < int'(DEPTH));
            g.delete();
            for (int unsigned k = 0; k < NS; k++) begin
                s = (mrr + k) % NS;
                if (mq[s].size() != 0 && g.size() < int'(NWP)) g.push_back(s);
            end
            for (int unsigned p = 0; p < NWP; p++) exp_ports[p] = '0;
            for (int p = 0; p < g.size(); p++) begin
                e = mq[g[p]].pop_front();
                exp_ports[p] = {1'b1, e};
            end
            if (g.size() > 0) mrr = (g[g.size()-1] + 1) % NS;
            for (int unsigned i = 0; i < NS; i++) begin
                if (src_valid[i] && rdy[i]) mq[i].push_back({src_index[i], src_data[i]});
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NS-1:0] er;
        if (model_on) begin
            for (int unsigned p = 0; p < NWP; p++)
                check($sformatf("model_port%0d", p), 64'(write_ports[p]), 64'(exp_ports[p]));
            for (int unsigned i = 0; i < NS; i++) er[i] = (mq[i].size() < int'(DEPTH)) && !rst;
            check("model_ready", 64'(src_ready), 64'(er));
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input int s, input int idx, input logic [31:0] d);
        src_valid[s] = 1'b1;
        src_index[s] = IW'(idx);
        src_data[s]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = '0;
        step();
        rst = 1'b0;
    endtask

    int gcnt [NS];

    initial begin
        rst = 1'b1;
        src_valid = '0;
        for (int i = 0; i < int'(NS); i++) begin
            src_index[i] = '0;
            src_data[i]  = '0;
        end

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_port0", 64'(write_ports[0]), 64'd0);
        check("reset_port1", 64'(write_ports[1]), 64'd0);
        check("reset_ready", 64'(src_ready), 64'hF);

        // Single write from source 2: visible two edges after the handshake
        push(2, 5, 32'hDEAD);
        step();
        src_valid = '0;
        @(negedge clk);
        check("single_early", 64'(write_ports[0].en), 64'd0);
        step();
        @(negedge clk);
        check("single_port0", 64'(write_ports[0]), pv(1'b1, 5, 32'hDEAD));
        check("single_port1_en", 64'(write_ports[1].en), 64'd0);
        // rr_ptr is now 3, so source 3 wins port 0 over source 0
        push(0, 1, 32'hA0);
        push(3, 2, 32'hB3);
        step();
        src_valid = '0;
        step();
        @(negedge clk);
        check("rr3_port0", 64'(write_ports[0]), pv(1'b1, 2, 32'hB3));
        check("rr3_port1", 64'(write_ports[1]), pv(1'b1, 1, 32'hA0));

        // Four simultaneous sources from rr_ptr=0
        do_reset();
        for (int s = 0; s < int'(NS); s++) push(s, 10 + s, 32'h100 + 32'(s));
        step();
        src_valid = '0;
        step();
        @(negedge clk);
        check("four_a_port0", 64'(write_ports[0]), pv(1'b1, 10, 32'h100));
        check("four_a_port1", 64'(write_ports[1]), pv(1'b1, 11, 32'h101));
        step();
        @(negedge clk);
        check("four_b_port0", 64'(write_ports[0]), pv(1'b1, 12, 32'h102));
        check("four_b_port1", 64'(write_ports[1]), pv(1'b1, 13, 32'h103));
        step();
        @(negedge clk);
        check("four_c_en", 64'({write_ports[1].en, write_ports[0].en}), 64'd0);
        // rr_ptr back at 0: source 0 beats source 3 for port 0
        push(3, 20, 32'h33);
        push(0, 21, 32'h30);
        step();
        src_valid = '0;
        step();
        @(negedge clk);
        check("four_rr0_port0", 64'(write_ports[0]), pv(1'b1, 21, 32'h30));
        check("four_rr0_port1", 64'(write_ports[1]), pv(1'b1, 20, 32'h33));

        // Backpressure on source 3 while sources 0 and 1 stay busy
        do_reset();
        for (int c = 0; c < 12; c++) begin
            push(0, c % 16, 32'h1000 + 32'(c));
            push(1, 16 + c % 16, 32'h2000 + 32'(c));
            push(3, 48 + c % 16, 32'h3000 + 32'(c));
            @(negedge clk);
            if (c == 1) check("bp_ready3_c1", 64'(src_ready[3]), 64'd1);
            if (c == 2) check("bp_ready3_c2", 64'(src_ready[3]), 64'd0);
            if (c == 3) check("bp_ready3_c3", 64'(src_ready[3]), 64'd1);
            step();
        end
        src_valid = '0;
        repeat (6) step();

        // Fairness: all sources continuously valid, grants alternate {0,1},{2,3}
        do_reset();
        for (int i = 0; i < int'(NS); i++) gcnt[i] = 0;
        for (int c = 0; c < 12; c++) begin
            for (int s = 0; s < int'(NS); s++) push(s, s * 16 + c % 16, 32'h4000 + 32'(s * 256 + c));
            @(negedge clk);
            if (c >= 2 && c < 10) begin
                check($sformatf("fair_p0_c%0d", c),
                      64'({write_ports[0].en, write_ports[0].index_in[IW-1 -: 2]}),
                      64'({1'b1, 2'(((c - 2) % 2) * 2)}));
                check($sformatf("fair_p1_c%0d", c),
                      64'({write_ports[1].en, write_ports[1].index_in[IW-1 -: 2]}),
                      64'({1'b1, 2'(((c - 2) % 2) * 2 + 1)}));
                for (int p = 0; p < int'(NWP); p++)
                    if (write_ports[p].en) gcnt[write_ports[p].index_in[IW-1 -: 2]]++;
            end
            step();
        end
        for (int s = 0; s < int'(NS); s++) check($sformatf("fair_count%0d", s), 64'(gcnt[s]), 64'd4);
        src_valid = '0;
        repeat (6) step();

        // Reset mid-flight discards everything queued and in flight
        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int s = 0; s < int'(NS); s++) push(s, s * 16 + 8 + c, 32'hBAD0 + 32'(s * 16 + c));
            step();
        end
        src_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_low", 64'(src_ready), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_en", 64'({write_ports[1].en, write_ports[0].en}), 64'd0);
        check("midrst_ready_high", 64'(src_ready), 64'hF);
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            check($sformatf("midrst_quiet%0d", c), 64'({write_ports[1].en, write_ports[0].en}), 64'd0);
        end

        // Same-edge push and pop on a FIFO holding one entry
        do_reset();
        push(0, 7, 32'hAAAA);
        step();
        push(0, 8, 32'hBBBB);
        @(negedge clk);
        check("pp_ready_before", 64'(src_ready[0]), 64'd1);
        step();
        src_valid = '0;
        @(negedge clk);
        check("pp_first", 64'(write_ports[0]), pv(1'b1, 7, 32'hAAAA));
        check("pp_ready_after", 64'(src_ready[0]), 64'd1);
        step();
        @(negedge clk);
        check("pp_second", 64'(write_ports[0]), pv(1'b1, 8, 32'hBBBB));
        step();
        @(negedge clk);
        check("pp_drained", 64'(write_ports[0].en), 64'd0);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
